// File: rtl/alu_sequencer_if.sv
// Handshake bundle between command source, alu_sequencer and the ALU.
// ALU_SEQ_STICKY_FLAG_EN adds the flag_clr signal.
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic                  cmd_use_acc;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_r;
    logic                  alu_flag;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_flag;
    logic                  busy;
`ifdef ALU_SEQ_STICKY_FLAG_EN
    logic                  flag_clr;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output res_ready, flag_clr, alu_r, alu_flag,
        input  cmd_ready, alu_op, alu_a, alu_b,
        input  res_valid, res_data, res_flag, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  res_ready, flag_clr, alu_r, alu_flag,
        output cmd_ready, alu_op, alu_a, alu_b,
        output res_valid, res_data, res_flag, busy
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output res_ready, alu_r, alu_flag,
        input  cmd_ready, alu_op, alu_a, alu_b,
        input  res_valid, res_data, res_flag, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  res_ready, alu_r, alu_flag,
        output cmd_ready, alu_op, alu_a, alu_b,
        output res_valid, res_data, res_flag, busy
    );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// Command-side initiator for the ALU: issue, wait latency, return result.
// Optional sticky result flag enabled by ALU_SEQ_STICKY_FLAG_EN.
module alu_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LATENCY = 1
) (
    input logic          clk,
    input logic          rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [3:0]            r_alu_op;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_res_flag;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_release;
    logic                  w_flag_next;

    assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_capture = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_release = (r_state == S_HOLD) && bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_WAIT;
            S_WAIT:  if (w_capture) w_next = S_HOLD;
            S_HOLD:  if (w_release) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
    end

`ifdef ALU_SEQ_STICKY_FLAG_EN
    // A capture on the same edge as a clear keeps only the fresh flag.
    always_comb begin
        w_flag_next = r_res_flag;
        if (w_capture && bus.flag_clr) w_flag_next = bus.alu_flag;
        else if (w_capture)            w_flag_next = r_res_flag | bus.alu_flag;
        else if (bus.flag_clr)         w_flag_next = 1'b0;
    end
`else
    always_comb begin
        w_flag_next = r_res_flag;
        if (w_capture) w_flag_next = bus.alu_flag;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_acc       <= '0;
            r_alu_op    <= 4'hf;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flag  <= 1'b0;
        end else begin
            r_res_flag <= w_flag_next;
            if (w_accept) begin
                r_alu_op <= bus.cmd_op;
                r_alu_a  <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
                r_alu_b  <= bus.cmd_b;
                r_cnt    <= 4'(ALU_LATENCY);
            end
            if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_capture) begin
                r_res_data  <= bus.alu_r;
                r_acc       <= bus.alu_r;
                r_res_valid <= 1'b1;
            end
            if (w_release)
                r_res_valid <= 1'b0;
        end
    end

    assign bus.alu_op    = r_alu_op;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_flag  = r_res_flag;
endmodule
